// File: rtl/wave_period_analyzer.sv
// Measures period, peaks and half peak-to-peak amplitude of an offset-binary waveform,
// using rising midscale crossings with a hysteresis band.
module wave_period_analyzer #(
  parameter int unsigned MID   = 127,
  parameter int unsigned HYST  = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       sample_in,
  input  logic             sample_valid,
  output logic [CNT_W-1:0] period,
  output logic [7:0]       peak_max,
  output logic [7:0]       peak_min,
  output logic [7:0]       amplitude,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout
);

  localparam logic [7:0]       LO   = 8'(MID - HYST);
  localparam logic [7:0]       HI   = 8'(MID + HYST);
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  typedef enum logic [1:0] {SYNC_LOW, SYNC_HIGH, MEAS_LOW, MEAS_HIGH} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       run_max_q, run_max_d;
  logic [7:0]       run_min_q, run_min_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [7:0]       peak_max_q, peak_max_d;
  logic [7:0]       peak_min_q, peak_min_d;
  logic [7:0]       amplitude_q, amplitude_d;
  logic             meas_valid_q, meas_valid_d;
  logic             locked_q, locked_d;
  logic             timeout_q, timeout_d;

  logic       is_low, is_high;
  logic [7:0] upd_max, upd_min, span;

  assign is_low  = (sample_in <= LO);
  assign is_high = (sample_in >= HI);
  assign upd_max = (sample_in > run_max_q) ? sample_in : run_max_q;
  assign upd_min = (sample_in < run_min_q) ? sample_in : run_min_q;
  assign span    = run_max_q - run_min_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    run_max_d    = run_max_q;
    run_min_d    = run_min_q;
    period_d     = period_q;
    peak_max_d   = peak_max_q;
    peak_min_d   = peak_min_q;
    amplitude_d  = amplitude_q;
    meas_valid_d = 1'b0;
    locked_d     = locked_q;
    timeout_d    = 1'b0;

    if (sample_valid) begin
      case (state_q)
        SYNC_LOW: begin
          if (is_low) state_d = SYNC_HIGH;
        end
        SYNC_HIGH: begin
          if (is_high) begin
            cnt_d     = ONE;
            run_max_d = sample_in;
            run_min_d = sample_in;
            state_d   = MEAS_LOW;
          end
        end
        default: begin
          // A crossing at a saturated count still measures; only a non-crossing sample times out.
          if (state_q == MEAS_HIGH && is_high) begin
            period_d     = cnt_q;
            peak_max_d   = run_max_q;
            peak_min_d   = run_min_q;
            amplitude_d  = {1'b0, span[7:1]};
            meas_valid_d = 1'b1;
            locked_d     = 1'b1;
            cnt_d        = ONE;
            run_max_d    = sample_in;
            run_min_d    = sample_in;
            state_d      = MEAS_LOW;
          end else if (cnt_q == CMAX) begin
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            cnt_d     = '0;
            state_d   = SYNC_LOW;
          end else begin
            cnt_d     = cnt_q + ONE;
            run_max_d = upd_max;
            run_min_d = upd_min;
            if (state_q == MEAS_LOW && is_low) state_d = MEAS_HIGH;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SYNC_LOW;
      cnt_q        <= '0;
      run_max_q    <= '0;
      run_min_q    <= '0;
      period_q     <= '0;
      peak_max_q   <= '0;
      peak_min_q   <= '0;
      amplitude_q  <= '0;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      run_max_q    <= run_max_d;
      run_min_q    <= run_min_d;
      period_q     <= period_d;
      peak_max_q   <= peak_max_d;
      peak_min_q   <= peak_min_d;
      amplitude_q  <= amplitude_d;
      meas_valid_q <= meas_valid_d;
      locked_q     <= locked_d;
      timeout_q    <= timeout_d;
    end
  end

  assign period     = period_q;
  assign peak_max   = peak_max_q;
  assign peak_min   = peak_min_q;
  assign amplitude  = amplitude_q;
  assign meas_valid = meas_valid_q;
  assign locked     = locked_q;
  assign timeout    = timeout_q;

endmodule
